phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_if.sv | 44 ++++
 rtl/phase_sequencer.sv | 150 +++++++++++++++
 tb/tb_phase_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// phase_sequencer_if
//
// Purpose : Bundles the run-control inputs and the phase/status outputs of the
//           phase sequencer so they travel as one port.
//
// Signals : start, step, stop  - single-cycle run-control pulses (to sequencer)
//           halt               - CPU has executed HLT, level (to sequencer)
//           cntrl_clk, alu_clk - phase strobes (from sequencer)
//           fetch              - fetch half of the instruction cycle
//           cpu_rst_           - active-low reset to the CPU
//           running, halted    - status
//           phase              - current phase 0..7
//           icount             - completed instruction cycles (CNT_W bits)
//
// Modports: master - the controller/CPU side, drives the control inputs
//           slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             step;
    logic             stop;
    logic             halt;
    logic             cntrl_clk;
    logic             alu_clk;
    logic             fetch;
    logic             cpu_rst_;
    logic             running;
    logic             halted;
    logic [2:0]       phase;
    logic [CNT_W-1:0] icount;

    modport master (
        output start, step, stop, halt,
        input  cntrl_clk, alu_clk, fetch, cpu_rst_, running, halted, phase, icount
    );

    modport slave (
        input  start, step, stop, halt,
        output cntrl_clk, alu_clk, fetch, cpu_rst_, running, halted, phase, icount
    );
endinterface

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Purpose : Generates the eight-phase instruction cycle for a simple CPU and
//           controls run / single-step / stop / halt, the CPU reset stretch and
//           a saturating count of completed instruction cycles.
//
// Ports   : clk  - sole clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - phase_sequencer_if.slave (control inputs, phase/status outputs)
//
// Parameters:
//           CNT_W    - width of icount
//           RST_HOLD - clk cycles cpu_rst_ stays low after rst deasserts
//
// Every output is decoded from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int CNT_W    = 16,
    parameter int RST_HOLD = 2
) (
    input  logic               clk,
    input  logic               rst,
    phase_sequencer_if.slave   bus
);

    localparam int HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        ph_q;
    logic [CNT_W-1:0]  icount_q;
    logic              stop_pending_q;
    logic [HOLD_W-1:0] hold_q;

    logic active;    // RUN or STEP: phases advance
    logic boundary;  // this edge closes an instruction cycle
    logic cmd_ok;    // CPU out of reset, control pulses are honoured

    assign active   = (state_q == RUN) || (state_q == STEP);
    assign boundary = active && (ph_q == 3'd7);
    assign cmd_ok   = (hold_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Phase, cycle counter, pending stop and CPU reset stretch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // A reset mid-cycle simply discards the cycle; icount is not bumped.
            ph_q           <= 3'd0;
            icount_q       <= '0;
            stop_pending_q <= 1'b0;
            hold_q         <= HOLD_W'(RST_HOLD);
        end else begin
            if (active) begin
                ph_q <= ph_q + 3'd1;  // 7 -> 0 wrap is the boundary reset
            end

            if (boundary && (icount_q != '1)) begin
                icount_q <= icount_q + CNT_W'(1);
            end

            // Remembered only while RUN continues; any exit from RUN drops it.
            if ((state_q == RUN) && (state_d == RUN)) begin
                stop_pending_q <= stop_pending_q | (bus.stop & cmd_ok);
            end else begin
                stop_pending_q <= 1'b0;
            end

            if (hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches whatever path the case statement takes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_ok && bus.start) begin
                    state_d = RUN;
                end else if (cmd_ok && bus.step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                // A stop landing on the boundary cycle itself counts too.
                if (boundary) begin
                    if (bus.halt) begin
                        state_d = HALTED;
                    end else if (stop_pending_q || (bus.stop && cmd_ok)) begin
                        state_d = IDLE;
                    end
                end
            end
            STEP: begin
                if (boundary) begin
                    state_d = bus.halt ? HALTED : IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (registers only)
    // -------------------------------------------------------------------------
    always_comb begin
        bus.cntrl_clk = active & ph_q[0];
        bus.alu_clk   = active & (ph_q[2:1] == 2'b11);
        bus.fetch     = active & ~ph_q[2];
        bus.running   = active;
        bus.halted    = (state_q == HALTED);
        bus.phase     = ph_q;
        bus.icount    = icount_q;
        bus.cpu_rst_  = cmd_ok;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Directed test of phase_sequencer. dut_a uses the default parameters; dut_b
// uses CNT_W=4 to reach icount saturation quickly. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int n_vec = 0;
    int n_err = 0;

    phase_sequencer_if #(.CNT_W(16)) bus_a ();
    phase_sequencer_if #(.CNT_W(4))  bus_b ();

    phase_sequencer #(.CNT_W(16), .RST_HOLD(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    phase_sequencer #(.CNT_W(4), .RST_HOLD(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_running"}, 32'(bus_a.running),   32'd0);
        check({tag, "_fetch"},   32'(bus_a.fetch),     32'd0);
        check({tag, "_cntrl"},   32'(bus_a.cntrl_clk), 32'd0);
        check({tag, "_alu"},     32'(bus_a.alu_clk),   32'd0);
        check({tag, "_phase"},   32'(bus_a.phase),     32'd0);
    endtask

    // Expected strobes per phase, bit p = value at ph==p.
    logic [7:0] fetch_tab = 8'b0000_1111;
    logic [7:0] cntrl_tab = 8'b1010_1010;
    logic [7:0] alu_tab   = 8'b1100_0000;

    initial begin
        int cnt;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0; bus_a.step = 1'b0; bus_a.stop = 1'b0; bus_a.halt = 1'b0;
        bus_b.start = 1'b0; bus_b.step = 1'b0; bus_b.stop = 1'b0; bus_b.halt = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check_idle_outputs("rst");
        check("rst_halted", 32'(bus_a.halted),   32'd0);
        check("rst_icount", 32'(bus_a.icount),   32'd0);
        check("rst_cpu_rst", 32'(bus_a.cpu_rst_), 32'd0);

        // ---------------- reset release, start gating ----------------
        rst_a = 1'b0;
        check("hold1_cpu_rst", 32'(bus_a.cpu_rst_), 32'd0);
        tick();
        check("hold2_cpu_rst", 32'(bus_a.cpu_rst_), 32'd0);
        bus_a.start = 1'b1;          // sampled on the edge where cpu_rst_ rises
        tick();
        bus_a.start = 1'b0;
        check("rise_cpu_rst", 32'(bus_a.cpu_rst_), 32'd1);
        check("early_start_ignored", 32'(bus_a.running), 32'd0);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("start_run", 32'(bus_a.running), 32'd1);

        // ---------------- phase strobes over one cycle ----------------
        for (int p = 0; p < 8; p++) begin
            check($sformatf("ph%0d_phase", p), 32'(bus_a.phase),     32'(p));
            check($sformatf("ph%0d_fetch", p), 32'(bus_a.fetch),     32'(fetch_tab[p]));
            check($sformatf("ph%0d_cntrl", p), 32'(bus_a.cntrl_clk), 32'(cntrl_tab[p]));
            check($sformatf("ph%0d_alu", p),   32'(bus_a.alu_clk),   32'(alu_tab[p]));
            tick();
        end
        check("b1_running", 32'(bus_a.running), 32'd1);
        check("b1_icount",  32'(bus_a.icount),  32'd1);
        check("b1_phase",   32'(bus_a.phase),   32'd0);

        // ---------------- stop at ph 2 ----------------
        tick(2);
        bus_a.stop = 1'b1;
        tick();
        bus_a.stop = 1'b0;
        check("stop2_ph3", 32'(bus_a.phase),   32'd3);
        tick(4);
        check("stop2_ph7_running", 32'(bus_a.running), 32'd1);
        tick();
        check_idle_outputs("stop2_idle");
        check("stop2_icount", 32'(bus_a.icount), 32'd2);

        // stop in IDLE must not leave a pending stop behind
        bus_a.stop = 1'b1;
        tick();
        bus_a.stop = 1'b0;

        // ---------------- stop exactly at ph 7 ----------------
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick(7);
        check("stop7_ph7", 32'(bus_a.phase), 32'd7);
        bus_a.stop = 1'b1;
        tick();
        bus_a.stop = 1'b0;
        check_idle_outputs("stop7_idle");
        check("stop7_icount", 32'(bus_a.icount), 32'd3);

        // ---------------- reset mid-cycle ----------------
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick(5);
        check("rstmid_ph5",    32'(bus_a.phase),  32'd5);
        check("rstmid_icount", 32'(bus_a.icount), 32'd3);
        rst_a = 1'b1;
        tick();
        check_idle_outputs("rstmid");
        check("rstmid_icount0", 32'(bus_a.icount),   32'd0);
        check("rstmid_cpu_rst", 32'(bus_a.cpu_rst_), 32'd0);
        tick();
        rst_a = 1'b0;
        cnt = 0;
        while (bus_a.cpu_rst_ == 1'b0 && cnt < 10) begin
            cnt++;
            tick();
        end
        check("rstmid_hold_cycles", 32'(cnt), 32'd2);

        // ---------------- single step, start ignored inside ----------------
        bus_a.step = 1'b1;
        tick();
        bus_a.step = 1'b0;
        cnt = 0;
        while (bus_a.running && cnt < 20) begin
            bus_a.start = (bus_a.phase == 3'd3);
            bus_a.stop  = (bus_a.phase == 3'd3);
            cnt++;
            tick();
        end
        bus_a.start = 1'b0;
        bus_a.stop  = 1'b0;
        check("step_cycles", 32'(cnt), 32'd8);
        check_idle_outputs("step_idle");
        check("step_icount", 32'(bus_a.icount), 32'd1);

        // ---------------- halt off-boundary has no effect ----------------
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick(2);
        bus_a.halt = 1'b1;           // ph 2 only
        tick();
        bus_a.halt = 1'b0;
        tick(5);
        check("halt_ph2_running", 32'(bus_a.running), 32'd1);
        check("halt_ph2_halted",  32'(bus_a.halted),  32'd0);
        check("halt_ph2_icount",  32'(bus_a.icount),  32'd2);

        // ---------------- halt raised at ph 4 ----------------
        tick(4);
        bus_a.halt = 1'b1;
        tick(3);
        check("halt_ph7_running", 32'(bus_a.running), 32'd1);
        tick();
        bus_a.halt = 1'b0;
        check("halt_halted",  32'(bus_a.halted),  32'd1);
        check("halt_icount",  32'(bus_a.icount),  32'd3);
        check_idle_outputs("halt");
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.step  = 1'b1;
        tick();
        bus_a.step  = 1'b0;
        tick();
        check("halt_start_ignored_halted",  32'(bus_a.halted),  32'd1);
        check("halt_start_ignored_running", 32'(bus_a.running), 32'd0);

        // ---------------- icount saturation, CNT_W = 4 ----------------
        rst_b = 1'b0;
        tick(2);
        check("sat_cpu_rst", 32'(bus_b.cpu_rst_), 32'd1);
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        tick(15 * 8);
        check("sat_icount15", 32'(bus_b.icount), 32'd15);
        tick(8);
        check("sat_icount16", 32'(bus_b.icount), 32'd15);
        tick(4 * 8);
        check("sat_icount20",  32'(bus_b.icount),  32'd15);
        check("sat_running",   32'(bus_b.running), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
